uart_pkt_fifo: RTL and testbench

UART_PKT_FIFO -- requirements
Module: uart_pkt_fifo

---
 rtl/uart_pkt_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_pkt_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_fifo.sv
// uart_pkt_fifo: captures one 5-byte packet per read_ready high period from
// uart_rx and queues it in a show-ahead packet FIFO. A packet that arrives
// while the FIFO is full is dropped. Each drop sets a sticky overflow flag
// and increments a saturating drop counter.
// Optional feature macro: UART_PKT_CHECKSUM_EN. When it is defined, a packet
// is accepted only if byte4 equals the XOR of byte0..byte3. A packet that
// fails this check is discarded and csum_err pulses for one cycle.
//
// state    | meaning
// WAIT_LOW | after reset; read_ready must be seen low before the first capture
// ARMED    | ready; the next high read_ready pushes one packet
// HELD     | packet taken; waiting for read_ready to fall
module uart_pkt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_19k2,
  input  logic        rst,
  input  logic        read_ready,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic [7:0]  byte2,
  input  logic [7:0]  byte3,
  input  logic [7:0]  byte4,
  input  logic        pkt_ready,
  input  logic        clr_ovf,
  output logic        pkt_valid,
  output logic [39:0] pkt_data,
  output logic [4:0]  count,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        csum_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic [39:0]     mem_q [DEPTH];
  logic [39:0]     mem_d [DEPTH];

  logic            push_req;
  logic            csum_ok;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            drop;
  logic [39:0]     push_data;

  assign push_data = {byte4, byte3, byte2, byte1, byte0};
  assign push_req  = (state_q == ARMED) && read_ready;
  assign full      = (count_q == 5'(DEPTH));
  assign pop       = pkt_valid_q && pkt_ready;
  assign wr_en     = push_req && csum_ok && (!full || pop);
  assign drop      = push_req && csum_ok && full && !pop;

`ifdef UART_PKT_CHECKSUM_EN
  logic csum_err_q, csum_err_d;

  assign csum_ok    = (byte4 == (byte0 ^ byte1 ^ byte2 ^ byte3));
  assign csum_err_d = push_req && !csum_ok;
  assign csum_err   = csum_err_q;

  // Registered one-cycle pulse for a packet rejected by the checksum check
  always_ff @(posedge clk_19k2 or negedge rst) begin
    if (!rst) csum_err_q <= 1'b0;
    else      csum_err_q <= csum_err_d;
  end
`else
  assign csum_ok  = 1'b1;
  assign csum_err = 1'b0;
`endif

  // Capture FSM next state: a single high level on read_ready gives one push request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOW: if (!read_ready) state_d = ARMED;
      ARMED:    if (read_ready)  state_d = HELD;
      HELD:     if (!read_ready) state_d = ARMED;
      default:  state_d = WAIT_LOW;
    endcase
  end

  // FIFO pointers, occupancy, storage, and overflow bookkeeping
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as clr_ovf counts as the first drop after the clear
    if (clr_ovf) begin
      overflow_d   = drop;
      drop_count_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    pkt_valid_d = (count_d != 5'd0);
  end

  // State and datapath registers; reset discards every stored packet
  always_ff @(posedge clk_19k2 or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_LOW;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 5'd0;
      pkt_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 40'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_valid_q  <= pkt_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign pkt_valid  = pkt_valid_q;
  assign pkt_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_pkt_fifo.sv
// Directed testbench for uart_pkt_fifo at DEPTH=4.
module tb_uart_pkt_fifo;

  logic        clk_19k2 = 1'b0;
  logic        rst;
  logic        read_ready;
  logic [7:0]  byte0, byte1, byte2, byte3, byte4;
  logic        pkt_ready;
  logic        clr_ovf;
  logic        pkt_valid;
  logic [39:0] pkt_data;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        csum_err;

  int errors = 0;
  int checks = 0;

  uart_pkt_fifo #(.DEPTH(4)) dut (
    .clk_19k2   (clk_19k2),
    .rst        (rst),
    .read_ready (read_ready),
    .byte0      (byte0),
    .byte1      (byte1),
    .byte2      (byte2),
    .byte3      (byte3),
    .byte4      (byte4),
    .pkt_ready  (pkt_ready),
    .clr_ovf    (clr_ovf),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .csum_err   (csum_err)
  );

  always #5 clk_19k2 = ~clk_19k2;

  // Builds a packet whose byte4 is the XOR of bytes 0..3, so it is valid in both builds.
  function automatic logic [39:0] mk(input logic [31:0] w);
    mk = {w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], w};
  endfunction

  task automatic step();
    @(posedge clk_19k2);
    #1;
  endtask

  task automatic set_bytes(input logic [39:0] v);
    {byte4, byte3, byte2, byte1, byte0} = v;
  endtask

  // One read_ready pulse of a single cycle, then low for one cycle so the FSM re-arms.
  task automatic send_pkt(input logic [39:0] v);
    set_bytes(v);
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    step();
  endtask

  task automatic drain();
    pkt_ready = 1'b1;
    repeat (6) step();
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; read_ready = 1'b0; pkt_ready = 1'b0; clr_ovf = 1'b0;
    set_bytes(40'd0);
    #12;
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", pkt_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({overflow, drop_count, csum_err} !== 10'd0) begin errors++; $display("FAIL reset_flags: got ovf=%0b drop=%0d csum=%0b want 0", overflow, drop_count, csum_err); end
    checks++; if (pkt_data !== 40'd0) begin errors++; $display("FAIL reset_data: got %h want 0", pkt_data); end
    @(negedge clk_19k2);
    rst = 1'b1;
    step();
  endtask

`ifndef UART_PKT_CHECKSUM_EN
  task automatic test_single();
    set_bytes({8'h89, 8'h81, 8'h0E, 8'hF7, 8'hC7});
    read_ready = 1'b1;
    step();
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", pkt_valid); end
    checks++; if (pkt_data !== 40'h89810EF7C7) begin errors++; $display("FAIL single_data: got %h want 89810ef7c7", pkt_data); end
    repeat (4) step();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_hold_count: got %0d want 1", count); end
    read_ready = 1'b0;
    step();
    pkt_ready = 1'b1;
    step();
    pkt_ready = 1'b0;
    checks++; if (pkt_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL single_pop: got valid=%0b count=%0d want 0 0", pkt_valid, count); end
  endtask
`else
  task automatic test_single();
    set_bytes({8'h89, 8'h81, 8'h0E, 8'hF7, 8'hC7});
    read_ready = 1'b1;
    step();
    checks++; if (csum_err !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL single_reject: got csum=%0b count=%0d want 1 0", csum_err, count); end
    repeat (4) step();
    read_ready = 1'b0;
    step();
  endtask
`endif

  task automatic test_overflow();
    logic [39:0] p [5];
    for (int i = 0; i < 5; i++) p[i] = mk(32'h1020_3040 + 32'(i * 32'h0101_0101));
    for (int i = 0; i < 5; i++) send_pkt(p[i]);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL ovf_flags: got ovf=%0b drop=%0d want 1 1", overflow, drop_count); end
    pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pkt_valid !== 1'b1 || pkt_data !== p[i]) begin errors++; $display("FAIL ovf_order%0d: got valid=%0b data=%h want 1 %h", i, pkt_valid, pkt_data, p[i]); end
      step();
    end
    pkt_ready = 1'b0;
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", pkt_valid); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clear: got ovf=%0b drop=%0d want 0 0", overflow, drop_count); end
  endtask

  task automatic test_full_push_pop();
    logic [39:0] p [5];
    for (int i = 0; i < 5; i++) p[i] = mk(32'hA0B0_C0D0 + 32'(i * 32'h0001_0203));
    for (int i = 0; i < 4; i++) send_pkt(p[i]);
    set_bytes(p[4]);
    read_ready = 1'b1;
    pkt_ready  = 1'b1;
    step();
    read_ready = 1'b0;
    pkt_ready  = 1'b0;
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %0b want 0", overflow); end
    step();
    pkt_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++; if (pkt_data !== p[i]) begin errors++; $display("FAIL fpp_order%0d: got %h want %h", i, pkt_data, p[i]); end
      step();
    end
    pkt_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fpp_drain: got %0d want 0", count); end
  endtask

  task automatic test_empty_push_pop();
    set_bytes(mk(32'h5566_7788));
    read_ready = 1'b1;
    pkt_ready  = 1'b1;
    step();
    read_ready = 1'b0;
    pkt_ready  = 1'b0;
    checks++; if (count !== 5'd1 || pkt_valid !== 1'b1) begin errors++; $display("FAIL epp_count: got count=%0d valid=%0b want 1 1", count, pkt_valid); end
    step();
    drain();
  endtask

  task automatic test_reset_midstream();
    send_pkt(mk(32'h0102_0304));
    send_pkt(mk(32'h1112_1314));
    set_bytes(mk(32'h2122_2324));
    read_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pkt_valid !== 1'b0 || count !== 5'd0 || pkt_data !== 40'd0) begin errors++; $display("FAIL mrst_fifo: got valid=%0b count=%0d data=%h want 0", pkt_valid, count, pkt_data); end
    checks++; if ({overflow, drop_count, csum_err} !== 10'd0) begin errors++; $display("FAIL mrst_flags: got ovf=%0b drop=%0d csum=%0b want 0", overflow, drop_count, csum_err); end
    @(negedge clk_19k2);
    rst = 1'b1;
    repeat (3) step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mrst_nocapture: got %0d want 0", count); end
    read_ready = 1'b0;
    step();
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    checks++; if (count !== 5'd1 || pkt_data !== mk(32'h2122_2324)) begin errors++; $display("FAIL mrst_recapture: got count=%0d data=%h want 1 %h", count, pkt_data, mk(32'h2122_2324)); end
    step();
    drain();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) send_pkt(mk(32'hCAFE_0000 + 32'(i)));
    for (int i = 0; i < 300; i++) send_pkt(mk(32'hDEAD_0000 + 32'(i)));
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL sat_drop: got ovf=%0b drop=%0d want 1 255", overflow, drop_count); end
    set_bytes(mk(32'hBEEF_0001));
    clr_ovf    = 1'b1;
    read_ready = 1'b1;
    step();
    clr_ovf    = 1'b0;
    read_ready = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL sat_clr_drop: got ovf=%0b drop=%0d want 1 1", overflow, drop_count); end
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL sat_clr: got ovf=%0b drop=%0d want 0 0", overflow, drop_count); end
    checks++; if (pkt_data !== mk(32'hCAFE_0000)) begin errors++; $display("FAIL sat_head: got %h want %h", pkt_data, mk(32'hCAFE_0000)); end
    drain();
  endtask

`ifdef UART_PKT_CHECKSUM_EN
  task automatic test_checksum();
    send_pkt({8'h0F, 8'h08, 8'h04, 8'h02, 8'h01});
    checks++; if (count !== 5'd1 || pkt_data !== 40'h0F08040201) begin errors++; $display("FAIL csum_good: got count=%0d data=%h want 1 0f08040201", count, pkt_data); end
    set_bytes({8'h0E, 8'h08, 8'h04, 8'h02, 8'h01});
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    checks++; if (csum_err !== 1'b1 || count !== 5'd1 || overflow !== 1'b0) begin errors++; $display("FAIL csum_bad: got csum=%0b count=%0d ovf=%0b want 1 1 0", csum_err, count, overflow); end
    step();
    checks++; if (csum_err !== 1'b0) begin errors++; $display("FAIL csum_pulse: got %0b want 0", csum_err); end
    drain();
  endtask
`else
  task automatic test_checksum();
    set_bytes({8'h0E, 8'h08, 8'h04, 8'h02, 8'h01});
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    checks++; if (csum_err !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL csum_off: got csum=%0b count=%0d want 0 1", csum_err, count); end
    step();
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_midstream();
    test_saturate();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
